// File: rtl/flow_ctrl.sv
`default_nettype none
// flow_ctrl: per-stage flow-code generator for the 5-stage pipeline.
// Resolves dmem wait, divide wait (with timeout), branch flush and load-use bubble.
module flow_ctrl #(
  parameter int DIV_MAX_CYC = 40,
  parameter int CNT_WIDTH   = 32,
  parameter int FLOW_WIDTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  jump_i,
  input  logic                  ld_hazard_i,
  input  logic                  div_busy_i,
  input  logic                  div_done_i,
  input  logic                  dmem_req_i,
  input  logic                  dmem_ready_i,
  output logic [FLOW_WIDTH-1:0] flow_pc_o,
  output logic [FLOW_WIDTH-1:0] flow_de_o,
  output logic [FLOW_WIDTH-1:0] flow_ex_o,
  output logic [FLOW_WIDTH-1:0] flow_mem_o,
  output logic [FLOW_WIDTH-1:0] flow_wb_o,
  output logic                  div_timeout_o,
  output logic [CNT_WIDTH-1:0]  stall_cnt_o
);

  localparam logic [FLOW_WIDTH-1:0] FLOW_WORK    = FLOW_WIDTH'(0);
  localparam logic [FLOW_WIDTH-1:0] FLOW_STOP    = FLOW_WIDTH'(1);
  localparam logic [FLOW_WIDTH-1:0] FLOW_REFRESH = FLOW_WIDTH'(2);

  localparam int DIV_CNT_W = (DIV_MAX_CYC > 1) ? $clog2(DIV_MAX_CYC) : 1;
  localparam logic [DIV_CNT_W-1:0] DIV_LAST = DIV_CNT_W'(DIV_MAX_CYC - 1);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    DIV_WAIT  = 2'd1,
    DMEM_WAIT = 2'd2
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [DIV_CNT_W-1:0]   div_cnt;
  logic [DIV_CNT_W-1:0]   div_cnt_nxt;
  logic                   resume_div;
  logic                   resume_div_nxt;
  logic                   timeout_set;
  logic                   dmem_stall;
  logic                   div_stall;

  assign dmem_stall = dmem_req_i & ~dmem_ready_i;
  assign div_stall  = div_busy_i & ~div_done_i;

  always_comb begin
    state_nxt      = state;
    div_cnt_nxt    = div_cnt;
    resume_div_nxt = resume_div;
    timeout_set    = 1'b0;
    flow_pc_o      = FLOW_WORK;
    flow_de_o      = FLOW_WORK;
    flow_ex_o      = FLOW_WORK;
    flow_mem_o     = FLOW_WORK;
    flow_wb_o      = FLOW_WORK;

    if (rst) begin
      flow_pc_o  = FLOW_REFRESH;
      flow_de_o  = FLOW_REFRESH;
      flow_ex_o  = FLOW_REFRESH;
      flow_mem_o = FLOW_REFRESH;
      flow_wb_o  = FLOW_REFRESH;
    end else begin
      case (state)
        RUN: begin
          if (dmem_stall) begin
            flow_pc_o      = FLOW_STOP;
            flow_de_o      = FLOW_STOP;
            flow_ex_o      = FLOW_STOP;
            flow_mem_o     = FLOW_STOP;
            flow_wb_o      = FLOW_REFRESH;
            state_nxt      = DMEM_WAIT;
            resume_div_nxt = 1'b0;
          end else if (div_stall) begin
            flow_pc_o   = FLOW_STOP;
            flow_de_o   = FLOW_STOP;
            flow_ex_o   = FLOW_STOP;
            flow_mem_o  = FLOW_REFRESH;
            state_nxt   = DIV_WAIT;
            div_cnt_nxt = '0;
          end else if (jump_i) begin
            // Jump beats a load-use hazard: the DE instruction is wrong-path anyway.
            flow_de_o = FLOW_REFRESH;
            flow_ex_o = FLOW_REFRESH;
          end else if (ld_hazard_i) begin
            flow_pc_o = FLOW_STOP;
            flow_de_o = FLOW_STOP;
            flow_ex_o = FLOW_REFRESH;
          end
        end

        DIV_WAIT: begin
          if (dmem_stall) begin
            // Memory stall preempts the divide; div_cnt is held until we come back.
            flow_pc_o      = FLOW_STOP;
            flow_de_o      = FLOW_STOP;
            flow_ex_o      = FLOW_STOP;
            flow_mem_o     = FLOW_STOP;
            flow_wb_o      = FLOW_REFRESH;
            state_nxt      = DMEM_WAIT;
            resume_div_nxt = 1'b1;
          end else if (div_done_i) begin
            state_nxt = RUN;
          end else if (div_cnt == DIV_LAST) begin
            timeout_set = 1'b1;
            state_nxt   = RUN;
          end else begin
            flow_pc_o   = FLOW_STOP;
            flow_de_o   = FLOW_STOP;
            flow_ex_o   = FLOW_STOP;
            flow_mem_o  = FLOW_REFRESH;
            div_cnt_nxt = div_cnt + DIV_CNT_W'(1);
          end
        end

        DMEM_WAIT: begin
          if (!dmem_ready_i) begin
            flow_pc_o  = FLOW_STOP;
            flow_de_o  = FLOW_STOP;
            flow_ex_o  = FLOW_STOP;
            flow_mem_o = FLOW_STOP;
            flow_wb_o  = FLOW_REFRESH;
          end else if (resume_div && div_stall) begin
            // Keep the pending divide held in EX while the memory access retires.
            flow_pc_o      = FLOW_STOP;
            flow_de_o      = FLOW_STOP;
            flow_ex_o      = FLOW_STOP;
            flow_mem_o     = FLOW_REFRESH;
            state_nxt      = DIV_WAIT;
            resume_div_nxt = 1'b0;
          end else begin
            state_nxt      = RUN;
            resume_div_nxt = 1'b0;
          end
        end

        default: begin
          state_nxt      = RUN;
          resume_div_nxt = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= RUN;
      div_cnt       <= '0;
      resume_div    <= 1'b0;
      div_timeout_o <= 1'b0;
      stall_cnt_o   <= '0;
    end else begin
      state      <= state_nxt;
      div_cnt    <= div_cnt_nxt;
      resume_div <= resume_div_nxt;
      if (timeout_set) begin
        div_timeout_o <= 1'b1;
      end
      if ((flow_pc_o == FLOW_STOP) && (stall_cnt_o != {CNT_WIDTH{1'b1}})) begin
        stall_cnt_o <= stall_cnt_o + CNT_WIDTH'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_flow_ctrl.sv
`default_nettype none
// tb_flow_ctrl: scoreboard bench; directed scenarios then random stimulus vs a cycle model.
module tb_flow_ctrl;

  localparam int DIV_MAX = 8;
  localparam int CW      = 6;
  localparam int SAT     = (1 << CW) - 1;

  localparam logic [1:0] W = 2'd0;
  localparam logic [1:0] S = 2'd1;
  localparam logic [1:0] R = 2'd2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic jump, ld, busy, done, req, rdy;
  logic [1:0] f_pc, f_de, f_ex, f_mem, f_wb;
  logic tmo;
  logic [CW-1:0] scnt;

  always #5 clk = ~clk;

  flow_ctrl #(.DIV_MAX_CYC(DIV_MAX), .CNT_WIDTH(CW), .FLOW_WIDTH(2)) dut (
    .clk(clk), .rst(rst),
    .jump_i(jump), .ld_hazard_i(ld), .div_busy_i(busy), .div_done_i(done),
    .dmem_req_i(req), .dmem_ready_i(rdy),
    .flow_pc_o(f_pc), .flow_de_o(f_de), .flow_ex_o(f_ex), .flow_mem_o(f_mem), .flow_wb_o(f_wb),
    .div_timeout_o(tmo), .stall_cnt_o(scnt)
  );

  typedef struct {
    int            id;
    logic [9:0]    flows;
    logic          tmo;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: pipeline condition flags rather than a state encoding.
  bit m_mem_stalled = 0;
  bit m_div_waiting = 0;
  int m_div_stalls  = 0;
  bit m_timeout     = 0;
  int m_stall       = 0;

  task automatic model_step(input bit r, j, l, b, d, q, y, output logic [9:0] f);
    logic [9:0] all_work, all_ref, dmem_f, div_f, jump_f, ld_f;
    all_work = {W, W, W, W, W};
    all_ref  = {R, R, R, R, R};
    dmem_f   = {S, S, S, S, R};
    div_f    = {S, S, S, R, W};
    jump_f   = {W, R, R, W, W};
    ld_f     = {S, S, R, W, W};
    if (r) begin
      f = all_ref;
      m_mem_stalled = 0; m_div_waiting = 0; m_div_stalls = 0;
      m_timeout = 0; m_stall = 0;
      return;
    end
    if (m_mem_stalled) begin
      if (!y) f = dmem_f;
      else begin
        m_mem_stalled = 0;
        if (m_div_waiting && b && !d) f = div_f;
        else begin f = all_work; m_div_waiting = 0; end
      end
    end else if (m_div_waiting) begin
      if (q && !y) begin f = dmem_f; m_mem_stalled = 1; end
      else if (d) begin f = all_work; m_div_waiting = 0; end
      else if (m_div_stalls == DIV_MAX) begin f = all_work; m_timeout = 1; m_div_waiting = 0; end
      else begin f = div_f; m_div_stalls++; end
    end else begin
      if (q && !y) begin f = dmem_f; m_mem_stalled = 1; end
      else if (b && !d) begin f = div_f; m_div_waiting = 1; m_div_stalls = 1; end
      else if (j) f = jump_f;
      else if (l) f = ld_f;
      else f = all_work;
    end
    if (f[9:8] == S && m_stall < SAT) m_stall++;
  endtask

  task automatic step(input bit r, j, l, b, d, q, y);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; jump = j; ld = l; busy = b; done = d; req = q; rdy = y;
    cyc++;
    e.id  = cyc;
    e.tmo = m_timeout;
    e.cnt = CW'(m_stall);
    model_step(r, j, l, b, d, q, y, e.flows);
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_checks++;
        if ({f_pc, f_de, f_ex, f_mem, f_wb} !== e.flows) begin
          n_fail++;
          $display("FAIL flows cyc=%0d got pc/de/ex/mem/wb=%h required=%h", e.id,
                   {f_pc, f_de, f_ex, f_mem, f_wb}, e.flows);
        end
        n_checks++;
        if (tmo !== e.tmo) begin
          n_fail++;
          $display("FAIL div_timeout cyc=%0d got=%b required=%b", e.id, tmo, e.tmo);
        end
        n_checks++;
        if (scnt !== e.cnt) begin
          n_fail++;
          $display("FAIL stall_cnt cyc=%0d got=%0d required=%0d", e.id, scnt, e.cnt);
        end
      end
    end
  end

  initial begin : stim
    bit r, j, l, b, d, q, y;
    int guard;
    jump = 0; ld = 0; busy = 0; done = 0; req = 0; rdy = 0;

    // reset then release
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    idle(2);
    // jump flush, jump with load hazard, plain load hazard
    step(0, 1, 0, 0, 0, 0, 0);
    idle(1);
    step(0, 1, 1, 0, 0, 0, 0);
    idle(1);
    step(0, 0, 1, 0, 0, 0, 0);
    idle(1);
    // divide finishing after 5 stall cycles
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0, 0);
    idle(2);
    // divide timeout, then sticky until reset
    for (int i = 0; i < DIV_MAX + 1; i++) step(0, 0, 0, 1, 0, 0, 0);
    idle(3);
    step(0, 1, 0, 0, 0, 0, 0);
    idle(1);
    step(1, 0, 0, 0, 0, 0, 0);
    idle(2);
    // dmem stall with pending jump
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 1, 0);
    step(0, 1, 0, 0, 0, 1, 1);
    step(0, 1, 0, 0, 0, 0, 0);
    idle(2);
    // dmem stall interrupting a divide, then resume and finish
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 1, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 1, 1);
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0, 0);
    idle(2);
    // counter saturation
    for (int i = 0; i < SAT + 10; i++) step(0, 0, 1, 0, 0, 0, 0);
    idle(2);
    step(1, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 299) == 0);
      j = ($urandom_range(0, 3) == 0);
      l = ($urandom_range(0, 3) == 0);
      b = ($urandom_range(0, 2) == 0);
      d = ($urandom_range(0, 4) == 0);
      q = ($urandom_range(0, 2) == 0);
      y = ($urandom_range(0, 1) == 0);
      step(r, j, l, b, d, q, y);
    end
    idle(2);

    guard = 0;
    while (sb.size() > 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    #1;
    if (sb.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain got=%0d pending required=0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
